// File: rtl/rc4_multicore_arbiter.sv
// Supervisor for NUM_CORES parallel RC4 brute-force cores: launches them, picks the
// first winner (lowest index on ties), detects total exhaustion and times the search.
module rc4_multicore_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24,
  parameter int CNT_WIDTH = 32,
  parameter int ID_WIDTH  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [NUM_CORES-1:0]           core_success,
  input  logic [NUM_CORES-1:0]           core_failure,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic                           cores_reset_n,
  output logic                           stop,
  output logic                           busy,
  output logic                           found,
  output logic                           all_failed,
  output logic [KEY_WIDTH-1:0]           winning_key,
  output logic [ID_WIDTH-1:0]            winner_id,
  output logic [CNT_WIDTH-1:0]           elapsed_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_FOUND, S_FAILED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_CORES-1:0]   fail_mask_q, fail_mask_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   crst_n_q, stop_q, busy_q, found_q, failed_q;

  logic                   hit;
  logic [ID_WIDTH-1:0]    hit_id;
  logic [KEY_WIDTH-1:0]   hit_key;
  logic                   all_fail;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Scan from the top down so the lowest-index success overwrites the rest.
  always_comb begin
    hit     = 1'b0;
    hit_id  = '0;
    hit_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_success[i]) begin
        hit     = 1'b1;
        hit_id  = ID_WIDTH'(i);
        hit_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  assign all_fail = &(fail_mask_q | core_failure);

  always_comb begin
    state_d     = state_q;
    fail_mask_d = fail_mask_q;
    key_d       = key_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE, S_FOUND, S_FAILED: begin
        if (start) begin
          state_d     = S_LAUNCH;
          fail_mask_d = '0;
          key_d       = '0;
          id_d        = '0;
          cnt_d       = '0;
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        cnt_d       = sat_inc(cnt_q);
        fail_mask_d = fail_mask_q | core_failure;
        if (hit) begin
          state_d = S_FOUND;
          key_d   = hit_key;
          id_d    = hit_id;
        end else if (all_fail) begin
          state_d = S_FAILED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      fail_mask_q <= '0;
      key_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      crst_n_q    <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      found_q     <= 1'b0;
      failed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_mask_q <= fail_mask_d;
      key_q       <= key_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      crst_n_q    <= (state_d == S_RUN) || (state_d == S_FOUND) || (state_d == S_FAILED);
      stop_q      <= (state_d == S_FOUND) || (state_d == S_FAILED);
      busy_q      <= (state_d == S_RUN);
      found_q     <= (state_d == S_FOUND);
      failed_q    <= (state_d == S_FAILED);
    end
  end

  assign cores_reset_n  = crst_n_q;
  assign stop           = stop_q;
  assign busy           = busy_q;
  assign found          = found_q;
  assign all_failed     = failed_q;
  assign winning_key    = key_q;
  assign winner_id      = id_q;
  assign elapsed_cycles = cnt_q;

endmodule

// File: tb/tb_rc4_multicore_arbiter.sv
// Scoreboard bench for rc4_multicore_arbiter: stimulus queues cycle-tagged expected
// output snapshots, a negedge monitor compares them against two DUT instances.
module tb_rc4_multicore_arbiter;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  core_success;
  logic [3:0]  core_failure;
  logic [95:0] core_key;

  logic        crst_n, stop, busy, found, all_failed;
  logic [23:0] winning_key;
  logic [1:0]  winner_id;
  logic [31:0] elapsed;

  logic        s_crst_n, s_stop, s_busy, s_found, s_failed;
  logic [23:0] s_key;
  logic [1:0]  s_id;
  logic [3:0]  s_elapsed;

  rc4_multicore_arbiter #(.NUM_CORES(4), .KEY_WIDTH(24), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .core_success(core_success), .core_failure(core_failure), .core_key(core_key),
    .cores_reset_n(crst_n), .stop(stop), .busy(busy), .found(found),
    .all_failed(all_failed), .winning_key(winning_key), .winner_id(winner_id),
    .elapsed_cycles(elapsed)
  );

  rc4_multicore_arbiter #(.NUM_CORES(4), .KEY_WIDTH(24), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start),
    .core_success(core_success), .core_failure(core_failure), .core_key(core_key),
    .cores_reset_n(s_crst_n), .stop(s_stop), .busy(s_busy), .found(s_found),
    .all_failed(s_failed), .winning_key(s_key), .winner_id(s_id),
    .elapsed_cycles(s_elapsed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [67:0] vec;  // {crst_n, stop, busy, found, all_failed, key, id, cnt32, cnt4}
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input string nm, input bit cr, input bit st,
                      input bit bz, input bit fd, input bit fl, input logic [23:0] key,
                      input logic [1:0] id, input logic [31:0] cnt);
    exp_t e;
    logic [3:0] c4;
    c4 = (cnt > 32'd15) ? 4'hF : cnt[3:0];
    e.cyc  = c;
    e.name = nm;
    e.vec  = {cr, st, bz, fd, fl, key, id, cnt, c4};
    sb.push_back(e);
  endtask

  task automatic push_zero(input int c, input string nm);
    push(c, nm, 0, 0, 0, 0, 0, 24'h0, 2'd0, 32'd0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [67:0] act;
    act = {crst_n, stop, busy, found, all_failed, winning_key, winner_id, elapsed, s_elapsed};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        if (act !== sb[i].vec) begin
          errors++;
          $display("FAIL %s @cyc%0d: got %h expected %h", sb[i].name, cyc, act, sb[i].vec);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    core_success = '0;
    core_failure = '0;
    core_key     = '0;
    step(2);
    reset_n = 1'b1;
    push_zero(cyc, "reset");
    push_zero(cyc + 5, "idle5");
    step(5);

    // Launch: one LAUNCH cycle, then cores released and counting from zero.
    start = 1'b1;
    push_zero(cyc + 1, "launch");
    push(cyc + 2, "run_entry", 1, 0, 1, 0, 0, 24'h0, 2'd0, 32'd0);
    step(1);
    start = 1'b0;
    step(1);
    push(cyc + 50, "run_mid", 1, 0, 1, 0, 0, 24'h0, 2'd0, 32'd50);
    step(99);

    core_key[0*24 +: 24] = 24'hAAAAAA;
    core_key[2*24 +: 24] = 24'h004A1F;
    core_success = 4'b0100;
    push(cyc + 1, "found_core2", 1, 1, 0, 1, 0, 24'h004A1F, 2'd2, 32'd100);
    step(1);
    core_success = 4'b0001;
    core_failure = 4'b1111;
    push(cyc + 3, "found_frozen", 1, 1, 0, 1, 0, 24'h004A1F, 2'd2, 32'd100);
    step(3);

    // Restart from FOUND, then a same-cycle tie between cores 1 and 3.
    start        = 1'b1;
    core_success = '0;
    core_failure = '0;
    push_zero(cyc + 1, "restart_found");
    step(1);
    start = 1'b0;
    push(cyc + 1, "run2_entry", 1, 0, 1, 0, 0, 24'h0, 2'd0, 32'd0);
    step(1);
    step(4);
    core_key[1*24 +: 24] = 24'h123456;
    core_key[3*24 +: 24] = 24'hFEDCBA;
    core_success = 4'b1010;
    core_failure = 4'b0001;
    push(cyc + 1, "tie_core1", 1, 1, 0, 1, 0, 24'h123456, 2'd1, 32'd5);
    step(1);
    core_success = '0;
    core_failure = '0;

    // Restart, then sticky single-cycle failures in order 3,0,2,1.
    start = 1'b1;
    push_zero(cyc + 1, "restart_tie");
    step(1);
    start = 1'b0;
    push(cyc + 1, "run3_entry", 1, 0, 1, 0, 0, 24'h0, 2'd0, 32'd0);
    step(1);
    core_failure = 4'b1000; step(1);
    core_failure = 4'b0000; step(1);
    core_failure = 4'b0001; step(1);
    core_failure = 4'b0100; step(1);
    core_failure = 4'b0000;
    push(cyc, "three_failed", 1, 0, 1, 0, 0, 24'h0, 2'd0, 32'd4);
    step(1);
    core_failure = 4'b0010;
    push(cyc + 1, "all_failed", 1, 1, 0, 0, 1, 24'h0, 2'd0, 32'd6);
    step(1);
    core_failure = 4'b0000;
    push(cyc + 2, "failed_frozen", 1, 1, 0, 0, 1, 24'h0, 2'd0, 32'd6);
    step(2);

    // Restart from FAILED, saturate the narrow counter, then abort with reset.
    start = 1'b1;
    push_zero(cyc + 1, "restart_failed");
    step(1);
    start = 1'b0;
    step(1);
    push(cyc + 15, "sat_15", 1, 0, 1, 0, 0, 24'h0, 2'd0, 32'd15);
    push(cyc + 16, "sat_16", 1, 0, 1, 0, 0, 24'h0, 2'd0, 32'd16);
    push(cyc + 20, "sat_20", 1, 0, 1, 0, 0, 24'h0, 2'd0, 32'd20);
    step(20);
    reset_n = 1'b0;
    push_zero(cyc + 1, "reset_mid_run");
    step(1);
    reset_n = 1'b1;
    push_zero(cyc + 3, "idle_after_reset");
    step(3);

    step(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
